dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and load/store sequencer in front of the byte-addressed data memory. It shares the single memory port between requester 0 (CPU load/store path) and requester 1 (debug/loader port) with round-robin arbitration. It performs byte/halfword stores as a single-cycle read-modify-write and sign- or zero-extends sub-word loads. The memory port drives the existing data memory: combinational 32-bit little-endian read at `addr`, and a full-word write at the posedge when the write strobe is high.

## Interface
- `RESET_LAST` (default 1): reset value of the last-grant pointer. 1 means requester 0 wins the first tie.

Ports:
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `mN_req` in, 1 (N=0,1): request. Held high, with all `mN_*` fields stable, until `mN_ack`.
- `mN_we` in, 1: 1 = store, 0 = load.
- `mN_size` in, 2: 00 byte, 01 half, 10 word, 11 illegal.
- `mN_unsigned` in, 1: zero-extend loads (LBU/LHU).
- `mN_addr` in, 32: byte address.
- `mN_wdata` in, 32: store data; the low bytes are used for sub-word stores.
- `mN_ack` out, 1: one-cycle completion pulse.
- `mN_err` out, 1: valid with `mN_ack`; set for an illegal size.
- `mN_rdata` out, 32: load result, registered.
- `mem_we` out, 1: memory write strobe.
- `mem_addr` out, 32: memory byte address.
- `mem_din` out, 32: memory write word.
- `mem_dout` in, 32: memory read word, combinational from `mem_addr`.
- `busy` out, 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - If any `req` is high, select the winner, latch its fields and the grant index, and go to ACCESS.
  - Otherwise stay in IDLE.
- **Arbitration:**
  - Only one requester high: it is granted.
  - Both high: grant the requester that is not `last`.
  - Update `last` to the granted index on the IDLE→ACCESS transition.
- **ACCESS** (exactly one cycle):
  - `mem_addr` = latched address.
  - Loads: capture the extended `mem_dout` into the granted `rdata` at the end of the cycle.
    - Byte: `dout[7:0]`.
    - Half: `dout[15:0]`.
    - Word: `dout`.
    - Sign-extend from bit 7 or 15 unless `unsigned` is set.
  - Stores: `mem_we`=1 and `mem_din` merges new data over the current word.
    - Byte: `{dout[31:8], wdata[7:0]}`.
    - Half: `{dout[31:16], wdata[15:0]}`.
    - Word: `wdata`.
  - Illegal size: no write, `rdata` unchanged, error flag latched.
  - Always go to RESP.
- **RESP:**
  - Granted `ack`=1, and `err` if latched.
  - Always go to IDLE.
- No alignment check: the memory is byte-addressed, so any address is legal.
- `rdata` of the non-granted requester never changes. `rdata` also does not change on stores.
- `mem_we` and `mem_din` are combinational from the state register, the latched fields and `mem_dout`. `mem_we` is 0 in every state except ACCESS.
- `mem_addr` holds the last latched address outside ACCESS.

## Timing
- **Latency:** `req` first seen high in IDLE at cycle N → ACCESS in N+1 (write takes effect at the end of N+1) → `ack` in N+2. The next request can be sampled at N+3.
- The requester must drop `req` at the edge ending the `ack` cycle. A `req` still high in the following IDLE cycle is a new request.
- **Back-to-back with both requesting continuously:** grants alternate 0,1,0,1…. Each transaction takes 3 cycles.
- **Requests arriving during ACCESS/RESP:** held and sampled at the next IDLE. None are dropped.
- **Reset** (asynchronous, effective immediately, including mid-ACCESS):
  - State → IDLE, `last` = `RESET_LAST`.
  - `mem_we`=0 immediately; an in-flight write is aborted if `rst` is high at the edge.
  - All `ack`/`err` = 0, all `rdata` = 0, `mem_addr` = 0, `busy` = 0.
  - The aborted requester receives no `ack` and must re-request.
- `ack` and `err` are registered (RESP decode) and never combinational from `req`.

## Test plan
- **Word round-trip:** m0 stores 0xDEADBEEF at 0x100, then loads it.
  - Store: `mem_we` high for exactly one cycle, `ack` 2 cycles after `req`.
  - Load: `m0_rdata`=0xDEADBEEF.
- **Byte RMW:** memory at 0x200 = 0x11223344; m1 stores byte 0xAA at 0x200.
  - Word becomes 0x112233AA.
  - Half store 0xBEEF at 0x201 gives bytes 0x200..0x203 = AA,EF,BE,11.
- **Load extension:** word 0x000080F0 at 0x300.
  - LB → 0xFFFFFFF0.
  - LBU → 0x000000F0.
  - LH → 0xFFFF80F0.
  - LHU → 0x000080F0.
- **Contention:** both `req` high from reset, each requester drops `req` after its ack and re-raises it next cycle.
  - Grant order is 0,1,0,1.
  - Each `ack` is followed by the other requester's access.
  - A requester's `rdata` is unchanged while the other requester is served.
- **Illegal size:** m0 `size`=11 with `we`=1.
  - `mem_we` stays 0; `ack` and `err` high together.
  - Memory contents and `m0_rdata` unchanged.
- **Reset mid-access:** assert `rst` during ACCESS of a store.
  - Outputs go to reset values within the same cycle; no `ack`; `busy`=0.
  - After release, a new m0 request completes normally with standard latency.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: two requester ports plus the shared data-memory port.
// slave = arbiter side, master = requesters/memory side.
interface dmem_arbiter_if;
  logic        m0_req, m0_we, m0_unsigned, m0_ack, m0_err;
  logic [1:0]  m0_size;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_unsigned, m1_ack, m1_err;
  logic [1:0]  m1_size;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        busy;

  modport slave (
    input  m0_req, m0_we, m0_unsigned, m0_size, m0_addr, m0_wdata,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_unsigned, m1_size, m1_addr, m1_wdata,
    output m1_ack, m1_err, m1_rdata,
    output mem_we, mem_addr, mem_din, busy,
    input  mem_dout
  );

  modport master (
    output m0_req, m0_we, m0_unsigned, m0_size, m0_addr, m0_wdata,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_we, m1_unsigned, m1_size, m1_addr, m1_wdata,
    input  m1_ack, m1_err, m1_rdata,
    input  mem_we, mem_addr, mem_din, busy,
    output mem_dout
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and load/store sequencer for the byte-addressed data memory.
// Sub-word stores are a single-cycle read-modify-write; sub-word loads are sign/zero extended.

// Per-requester response slice: load result register and ack/err decode.
module dmem_arb_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        cap,
  input  logic        resp,
  input  logic        bad,
  input  logic [31:0] ext,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err
);
  always_ff @(posedge clk or posedge rst)
    if (rst)            rdata <= '0;
    else if (sel & cap) rdata <= ext;

  assign ack = resp & sel;
  assign err = resp & sel & bad;
endmodule

module dmem_arbiter #(
  parameter bit RESET_LAST = 1'b1
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int NREQ = 2;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                      state, nxt;
  req_t   [NREQ-1:0]           rq;
  logic   [NREQ-1:0]           req_v, sel, ack, err;
  logic   [NREQ-1:0][31:0]     rdata;
  req_t                        lat;
  logic                        gnt, last, win, bad, cap;
  logic   [31:0]               dout, ext;

  assign req_v = {bus.m1_req, bus.m0_req};
  assign rq[0] = {bus.m0_we, bus.m0_size, bus.m0_unsigned, bus.m0_addr, bus.m0_wdata};
  assign rq[1] = {bus.m1_we, bus.m1_size, bus.m1_unsigned, bus.m1_addr, bus.m1_wdata};
  assign dout  = bus.mem_dout;

  // On a tie the requester that was not served last wins.
  assign win = (&req_v) ? ~last : req_v[1];
  assign bad = (lat.size == 2'b11);
  assign sel = {gnt, ~gnt};

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (|req_v) nxt = ACCESS;
      ACCESS:  nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lat  <= '0;
      gnt  <= 1'b0;
      last <= RESET_LAST;
    end else if (state == IDLE && |req_v) begin
      lat  <= rq[win];
      gnt  <= win;
      last <= win;
    end

  always_comb begin
    ext = dout;
    unique case (lat.size)
      2'b00:   ext = {{24{~lat.uns & dout[7]}},  dout[7:0]};
      2'b01:   ext = {{16{~lat.uns & dout[15]}}, dout[15:0]};
      default: ext = dout;
    endcase
  end

  assign cap = (state == ACCESS) & ~lat.we & ~bad;

  // Memory port: write only in ACCESS, merging new low bytes over the current word.
  always_comb begin
    bus.mem_we  = (state == ACCESS) & lat.we & ~bad;
    bus.mem_din = lat.wdata;
    unique case (lat.size)
      2'b00:   bus.mem_din = {dout[31:8],  lat.wdata[7:0]};
      2'b01:   bus.mem_din = {dout[31:16], lat.wdata[15:0]};
      default: bus.mem_din = lat.wdata;
    endcase
    bus.mem_addr = lat.addr;
    bus.busy     = (state != IDLE);
  end

  for (genvar n = 0; n < NREQ; n++) begin : g_port
    dmem_arb_port u_port (
      .clk   (clk),
      .rst   (rst),
      .sel   (sel[n]),
      .cap   (cap),
      .resp  (state == RESP),
      .bad   (bad),
      .ext   (ext),
      .rdata (rdata[n]),
      .ack   (ack[n]),
      .err   (err[n])
    );
  end

  assign bus.m0_rdata = rdata[0];
  assign bus.m1_rdata = rdata[1];
  assign bus.m0_ack   = ack[0];
  assign bus.m1_ack   = ack[1];
  assign bus.m0_err   = err[0];
  assign bus.m1_err   = err[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: byte-array memory model, hand-computed expected values.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  dmem_arbiter_if bus();

  dmem_arbiter #(.RESET_LAST(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int errs = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory: combinational little-endian read, full-word write at posedge.
  logic [7:0]  mem [0:1023];
  logic [9:0]  ma, poke_a;
  logic [31:0] poke_d;
  logic        poke_en = 1'b0;
  assign ma = bus.mem_addr[9:0];
  assign bus.mem_dout = {mem[ma+10'd3], mem[ma+10'd2], mem[ma+10'd1], mem[ma]};

  always @(posedge clk)
    if (bus.mem_we) begin
      mem[ma] <= bus.mem_din[7:0];        mem[ma+10'd1] <= bus.mem_din[15:8];
      mem[ma+10'd2] <= bus.mem_din[23:16]; mem[ma+10'd3] <= bus.mem_din[31:24];
    end else if (poke_en) begin
      mem[poke_a] <= poke_d[7:0];           mem[poke_a+10'd1] <= poke_d[15:8];
      mem[poke_a+10'd2] <= poke_d[23:16];   mem[poke_a+10'd3] <= poke_d[31:24];
    end

  function automatic logic [31:0] peek(input logic [9:0] a);
    return {mem[a+10'd3], mem[a+10'd2], mem[a+10'd1], mem[a]};
  endfunction

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    poke_a = a; poke_d = d; poke_en = 1'b1;
    @(posedge clk); #1 poke_en = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on port p; called and returns at posedge+1 with the arbiter idle.
  task automatic xact(input bit p, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat, output int wes);
    logic ak;
    if (!p) begin
      bus.m0_we = we; bus.m0_size = sz; bus.m0_unsigned = uns;
      bus.m0_addr = a; bus.m0_wdata = wd; bus.m0_req = 1'b1;
    end else begin
      bus.m1_we = we; bus.m1_size = sz; bus.m1_unsigned = uns;
      bus.m1_addr = a; bus.m1_wdata = wd; bus.m1_req = 1'b1;
    end
    lat = 0; wes = 0; ak = 1'b0;
    while (!ak && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.mem_we) wes++;
      ak = p ? bus.m1_ack : bus.m0_ack;
    end
    rd = p ? bus.m1_rdata : bus.m0_rdata;
    er = p ? bus.m1_err : bus.m0_err;
    @(posedge clk); #1;
    if (!p) bus.m0_req = 1'b0; else bus.m1_req = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, wes;
  int          order[$], ack_cyc[$];

  initial begin
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_size = 0; bus.m0_unsigned = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_size = 0; bus.m1_unsigned = 0; bus.m1_addr = 0; bus.m1_wdata = 0;

    @(posedge clk); #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_rdata0", bus.m0_rdata, 0);
    chk("rst_rdata1", bus.m1_rdata, 0);
    chk("rst_acks", {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Word round-trip on m0
    xact(0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, rd, er, lat, wes);
    chk("sw_latency", lat, 3);
    chk("sw_we_cycles", wes, 1);
    chk("sw_err", er, 0);
    chk("sw_mem", peek(10'h100), 32'hDEADBEEF);
    chk("sw_rdata_kept", rd, 0);
    xact(0, 0, 2'b10, 0, 32'h100, 0, rd, er, lat, wes);
    chk("lw_latency", lat, 3);
    chk("lw_no_we", wes, 0);
    chk("lw_rdata", rd, 32'hDEADBEEF);

    // Byte/half read-modify-write on m1
    poke(10'h200, 32'h11223344);
    poke(10'h204, 32'h0);
    xact(1, 1, 2'b00, 0, 32'h200, 32'hFFFFFFAA, rd, er, lat, wes);
    chk("sb_mem", peek(10'h200), 32'h112233AA);
    chk("sb_latency", lat, 3);
    xact(1, 1, 2'b01, 0, 32'h201, 32'h1234BEEF, rd, er, lat, wes);
    chk("sh_mem", peek(10'h200), 32'h11BEEFAA);
    chk("sh_rdata1_kept", rd, 0);
    chk("sh_rdata0_kept", bus.m0_rdata, 32'hDEADBEEF);

    // Load extension
    poke(10'h300, 32'h000080F0);
    xact(0, 0, 2'b00, 0, 32'h300, 0, rd, er, lat, wes);
    chk("lb", rd, 32'hFFFFFFF0);
    xact(1, 0, 2'b00, 1, 32'h300, 0, rd, er, lat, wes);
    chk("lbu", rd, 32'h000000F0);
    xact(0, 0, 2'b01, 0, 32'h300, 0, rd, er, lat, wes);
    chk("lh", rd, 32'hFFFF80F0);
    xact(1, 0, 2'b01, 1, 32'h300, 0, rd, er, lat, wes);
    chk("lhu", rd, 32'h000080F0);

    // Illegal size store
    xact(0, 1, 2'b11, 0, 32'h100, 32'h0, rd, er, lat, wes);
    chk("ill_we", wes, 0);
    chk("ill_err", er, 1);
    chk("ill_latency", lat, 3);
    chk("ill_rdata", rd, 32'hFFFF80F0);
    chk("ill_mem", peek(10'h100), 32'hDEADBEEF);

    // Contention from reset
    rst = 1'b1;
    #1 chk("rst2_rdata0", bus.m0_rdata, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    fork
      begin : p0
        int n;
        for (int k = 0; k < 2; k++) begin
          bus.m0_we = 0; bus.m0_size = 2'b10; bus.m0_addr = (k == 0) ? 32'h300 : 32'h200;
          bus.m0_req = 1'b1;
          n = 0;
          do begin @(negedge clk); n++; end while (!bus.m0_ack && n < 30);
          chk("c0_ack", bus.m0_ack, 1);
          order.push_back(0); ack_cyc.push_back(cyc);
          chk("c0_rdata", bus.m0_rdata, (k == 0) ? 32'h000080F0 : 32'h11BEEFAA);
          if (k == 1) chk("c0_m1_kept", bus.m1_rdata, 32'hDEADBEEF);
          @(posedge clk); #1 bus.m0_req = 1'b0;
          @(posedge clk); #1;
        end
      end
      begin : p1
        int n;
        for (int k = 0; k < 2; k++) begin
          bus.m1_we = 0; bus.m1_size = 2'b10; bus.m1_addr = (k == 0) ? 32'h100 : 32'h300;
          bus.m1_req = 1'b1;
          n = 0;
          do begin @(negedge clk); n++; end while (!bus.m1_ack && n < 30);
          chk("c1_ack", bus.m1_ack, 1);
          order.push_back(1); ack_cyc.push_back(cyc);
          chk("c1_rdata", bus.m1_rdata, (k == 0) ? 32'hDEADBEEF : 32'h000080F0);
          chk("c1_m0_kept", bus.m0_rdata, (k == 0) ? 32'h000080F0 : 32'h11BEEFAA);
          @(posedge clk); #1 bus.m1_req = 1'b0;
          @(posedge clk); #1;
        end
      end
    join
    chk("c_count", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      chk("c_order", order[i], i % 2);
      if (i > 0) chk("c_spacing", ack_cyc[i] - ack_cyc[i-1], 3);
    end
    @(posedge clk); #1;

    // Reset during the ACCESS cycle of a store
    bus.m0_we = 1; bus.m0_size = 2'b10; bus.m0_unsigned = 0;
    bus.m0_addr = 32'h100; bus.m0_wdata = 32'h12345678; bus.m0_req = 1'b1;
    @(posedge clk); #1;
    chk("ra_busy_pre", bus.busy, 1);
    chk("ra_we_pre", bus.mem_we, 1);
    rst = 1'b1; bus.m0_req = 1'b0;
    #1;
    chk("ra_we", bus.mem_we, 0);
    chk("ra_busy", bus.busy, 0);
    chk("ra_addr", bus.mem_addr, 0);
    chk("ra_rdata", {bus.m0_rdata | bus.m1_rdata}, 0);
    @(negedge clk) chk("ra_ack_a", bus.m0_ack, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) chk("ra_ack_b", {bus.m0_ack, bus.busy}, 0);
    chk("ra_mem", peek(10'h100), 32'hDEADBEEF);
    @(posedge clk); #1;
    xact(0, 0, 2'b10, 0, 32'h100, 0, rd, er, lat, wes);
    chk("ra_relat", lat, 3);
    chk("ra_reload", rd, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
